// File: rtl/spi_reg_pkg.sv
// Shared types and command-frame layout for the SPI register bank.
package spi_reg_pkg;

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;
    localparam int CMD_LEN      = 8;

    typedef logic [CMD_ADDR_MSB:0] addr_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings SCLK/MOSI/CS_n into the clk_i domain and turns synced SCLK transitions
// into one-cycle sample/shift pulses.
module spi_sync_edge #(
    parameter bit SAMPLE_RISE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic sample_pulse,
    output logic shift_pulse,
    output logic mosi_s,
    output logic cs_n_s
);

    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [1:0] cs_sync;
    logic       sclk_d;
    logic       rise;
    logic       fall;

    // CS resets to deselected so a reset never looks like the start of a frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= 2'b11;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_sync   <= {cs_sync[0], cs_n};
            sclk_d    <= sclk_sync[1];
        end
    end

    assign rise         = sclk_sync[1] & ~sclk_d;
    assign fall         = ~sclk_sync[1] & sclk_d;
    assign sample_pulse = SAMPLE_RISE ? rise : fall;
    assign shift_pulse  = SAMPLE_RISE ? fall : rise;
    assign mosi_s       = mosi_sync[1];
    assign cs_n_s       = cs_sync[1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-slave register bank: command byte (R/W + start address) followed by any
// number of data frames, with address auto-increment and MISO read-back.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                            NUM_REGS     = 8,
    parameter int                            REG_WIDTH    = 8,
    parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUES = '0,
    parameter bit                            SAMPLE_RISE  = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          spi_sclk_i,
    input  logic                          spi_mosi_i,
    input  logic                          spi_cs_ni,
    output logic                          spi_miso_o,
    output logic                          spi_miso_oe,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]           wr_strobe_o
);

    localparam int AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(max_int(CMD_LEN, REG_WIDTH));

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_WIDTH - 1);
    localparam addr_t            LAST_ADDR = addr_t'(NUM_REGS - 1);
    localparam logic [7:0]       REG_COUNT = 8'(NUM_REGS);

    logic sample_pulse, shift_pulse, mosi_s, cs_n_s;

    spi_sync_edge #(.SAMPLE_RISE(SAMPLE_RISE)) u_sync (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sclk         (spi_sclk_i),
        .mosi         (spi_mosi_i),
        .cs_n         (spi_cs_ni),
        .sample_pulse (sample_pulse),
        .shift_pulse  (shift_pulse),
        .mosi_s       (mosi_s),
        .cs_n_s       (cs_n_s)
    );

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    addr_t                addr;
    logic [CMD_LEN-2:0]   cmd_sr;
    logic [REG_WIDTH-1:0] wdata_sr;
    logic [REG_WIDTH-1:0] rdata_sr;
    logic [REG_WIDTH-1:0] regs [NUM_REGS];
    logic                 wr_pend;
    logic                 rd_pend;

    logic                 samp, shft, in_range;
    logic [AW-1:0]        addr_idx;
    addr_t                next_addr;
    logic [CMD_LEN-1:0]   cmd_word;
    logic [REG_WIDTH:0]   wdata_cat;
    logic [REG_WIDTH-1:0] rd_word;
    logic [REG_WIDTH-1:0] rshift;

    assign samp      = sample_pulse & enable_i;
    assign shft      = shift_pulse & enable_i;
    assign in_range  = {1'b0, addr} < REG_COUNT;
    assign addr_idx  = addr[AW-1:0];
    assign next_addr = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    assign cmd_word  = {cmd_sr, mosi_s};
    assign wdata_cat = {wdata_sr, mosi_s};
    assign rshift    = rdata_sr << 1;

    always_comb begin
        rd_word = '0;
        if (in_range) rd_word = regs[addr_idx];
    end

    // A shift edge with bit_cnt==0 is the one between frames: the freshly loaded
    // MSB is already on MISO and must not be shifted away.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= CMD;
            bit_cnt     <= '0;
            addr        <= '0;
            cmd_sr      <= '0;
            wdata_sr    <= '0;
            rdata_sr    <= '0;
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
            spi_miso_o  <= 1'b0;
            spi_miso_oe <= 1'b0;
            wr_strobe_o <= '0;
            // NOTE: the register array is configuration state, so it takes its
            // reset values too; a memory without reset would come up as X.
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VALUES[i*REG_WIDTH +: REG_WIDTH];
        end else begin
            wr_strobe_o <= '0;

            if (wr_pend) begin
                wr_pend <= 1'b0;
                addr    <= next_addr;
                if (in_range) begin
                    regs[addr_idx]        <= wdata_sr;
                    wr_strobe_o[addr_idx] <= 1'b1;
                end
            end

            if (rd_pend) begin
                rd_pend     <= 1'b0;
                rdata_sr    <= rd_word;
                spi_miso_o  <= rd_word[REG_WIDTH-1];
                spi_miso_oe <= 1'b1;
            end

            if (cs_n_s) begin
                state       <= IDLE;
                bit_cnt     <= '0;
                rd_pend     <= 1'b0;
                spi_miso_o  <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state   <= CMD;
                        bit_cnt <= '0;
                    end
                    CMD: if (samp) begin
                        cmd_sr <= cmd_word[CMD_LEN-2:0];
                        if (bit_cnt == CMD_LAST) begin
                            bit_cnt <= '0;
                            addr    <= cmd_word[CMD_ADDR_MSB:0];
                            if (cmd_word[CMD_RW_BIT]) begin
                                state   <= RDATA;
                                rd_pend <= 1'b1;
                            end else begin
                                state <= WDATA;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    WDATA: if (samp) begin
                        wdata_sr <= wdata_cat[REG_WIDTH-1:0];
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            wr_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    RDATA: begin
                        if (samp) begin
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                addr    <= next_addr;
                                rd_pend <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (shft && bit_cnt != '0) begin
                            rdata_sr   <= rshift;
                            spi_miso_o <= rshift[REG_WIDTH-1];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*REG_WIDTH +: REG_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: mode-0 SPI master tasks and a shadow copy of
// the register contents updated by hand-computed expectations.
module tb_spi_reg_bank;

    localparam int         NR = 8;
    localparam int         RW = 8;
    localparam logic [63:0] RV = 64'h8877_6655_4433_2211;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic        miso;
    logic        miso_oe;
    logic [63:0] regs;
    logic [7:0]  wr_strobe;

    logic [63:0] exp_regs;
    logic [7:0]  strobe_or;
    int          strobe_cnt;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  rx;
    logic [7:0]  oe;

    always #5 clk = ~clk;

    spi_reg_bank #(
        .NUM_REGS     (NR),
        .REG_WIDTH    (RW),
        .RESET_VALUES (RV),
        .SAMPLE_RISE  (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .spi_sclk_i  (sclk),
        .spi_mosi_i  (mosi),
        .spi_cs_ni   (cs_n),
        .spi_miso_o  (miso),
        .spi_miso_oe (miso_oe),
        .regs_o      (regs),
        .wr_strobe_o (wr_strobe)
    );

    always @(negedge clk) begin
        if (wr_strobe != '0) begin
            strobe_or  = strobe_or | wr_strobe;
            strobe_cnt = strobe_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Sends the top n bits of tx MSB first; captures MISO and OE at each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx_bits, output logic [7:0] oe_bits);
        rx_bits = '0;
        oe_bits = '0;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            rx_bits[7-i] = miso;
            oe_bits[7-i] = miso_oe;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        strobe_or  = '0;
        strobe_cnt = 0;
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        strobe_or  = '0;
        strobe_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_regs", regs, RV);
        check("rst_strobe", wr_strobe, 8'h00);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_miso", miso, 1'b0);
        rst = 1'b0;
        exp_regs = RV;
        repeat (4) @(negedge clk);

        // Single write
        cs_begin();
        spi_bits(8'h02, 8, rx, oe);
        spi_bits(8'hA5, 8, rx, oe);
        cs_end();
        exp_regs[2*RW +: RW] = 8'hA5;
        check("wr_regs", regs, exp_regs);
        check("wr_strobe_bits", strobe_or, 8'h04);
        check("wr_strobe_len", strobe_cnt, 1);

        // Burst write wrapping 7 -> 0
        cs_begin();
        spi_bits(8'h06, 8, rx, oe);
        spi_bits(8'h11, 8, rx, oe);
        spi_bits(8'h22, 8, rx, oe);
        spi_bits(8'h33, 8, rx, oe);
        cs_end();
        exp_regs[6*RW +: RW] = 8'h11;
        exp_regs[7*RW +: RW] = 8'h22;
        exp_regs[0*RW +: RW] = 8'h33;
        check("burst_regs", regs, exp_regs);
        check("burst_strobe_bits", strobe_or, 8'hC1);
        check("burst_strobe_len", strobe_cnt, 3);

        // Burst read from 2: reg2 then reg3
        cs_begin();
        spi_bits(8'h82, 8, rx, oe);
        check("rd_cmd_oe", oe, 8'h00);
        spi_bits(8'h00, 8, rx, oe);
        check("rd_data0", rx, 8'hA5);
        check("rd_oe0", oe, 8'hFF);
        spi_bits(8'h00, 8, rx, oe);
        check("rd_data1", rx, 8'h44);
        check("rd_oe1", oe, 8'hFF);
        cs_end();
        check("rd_oe_off", miso_oe, 1'b0);
        check("rd_no_strobe", strobe_cnt, 0);

        // Aborted partial frame, then a complete one
        cs_begin();
        spi_bits(8'h01, 8, rx, oe);
        spi_bits(8'hFF, 5, rx, oe);
        cs_end();
        check("abort_regs", regs, exp_regs);
        check("abort_strobe", strobe_cnt, 0);
        cs_begin();
        spi_bits(8'h01, 8, rx, oe);
        spi_bits(8'h3C, 8, rx, oe);
        cs_end();
        exp_regs[1*RW +: RW] = 8'h3C;
        check("after_abort_regs", regs, exp_regs);
        check("after_abort_strobe", strobe_or, 8'h02);

        // Out-of-range write and read
        cs_begin();
        spi_bits(8'h7F, 8, rx, oe);
        spi_bits(8'hFF, 8, rx, oe);
        cs_end();
        check("oor_wr_regs", regs, exp_regs);
        check("oor_wr_strobe", strobe_cnt, 0);
        cs_begin();
        spi_bits(8'hFF, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        check("oor_rd_data", rx, 8'h00);
        cs_end();

        // enable_i low mid-frame: extra edges are ignored
        cs_begin();
        spi_bits(8'h05, 8, rx, oe);
        spi_bits(8'h5A, 4, rx, oe);
        enable = 1'b0;
        mosi = 1'b1;
        for (int k = 0; k < 3; k++) begin
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        enable = 1'b1;
        spi_bits(8'hA0, 4, rx, oe);
        cs_end();
        exp_regs[5*RW +: RW] = 8'h5A;
        check("enable_regs", regs, exp_regs);
        check("enable_strobe", strobe_or, 8'h20);

        // Reset mid-burst
        cs_begin();
        spi_bits(8'h00, 8, rx, oe);
        spi_bits(8'h99, 8, rx, oe);
        spi_bits(8'h77, 3, rx, oe);
        exp_regs[0*RW +: RW] = 8'h99;
        check("pre_reset_regs", regs, exp_regs);
        rst = 1'b1;
        #1;
        check("mid_reset_regs", regs, RV);
        check("mid_reset_strobe", wr_strobe, 8'h00);
        check("mid_reset_oe", miso_oe, 1'b0);
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        exp_regs = RV;
        repeat (5) @(negedge clk);
        check("post_reset_regs", regs, exp_regs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
